posit_mult_stream: RTL and testbench
====================================

// Module: posit_mult_stream
// PURPOSE
//   Valid/ready streaming shell around the 4-stage es=2 posit multiplier (positmult_4).
//   Accepts operand pairs on a ready/valid input, issues them to the free-running multiplier
//   as single-cycle start pulses, and captures every done pulse into an output FIFO.
//   Credit-based issue guarantees a result is never dropped, even though the multiplier has no backpressure.
// PARAMETERS
//   NBITS    32  posit width (fixed at 32 to match the multiplier)
//   LATENCY  4   cycles from mul_start high to mul_done high
//   DEPTH    8   output FIFO entries, >=2; DEPTH >= LATENCY+2 sustains 1 op/cycle
// PORTS
//   clk         in   1      clock, all state on rising edge
//   reset       in   1      synchronous, active-high
//   in_valid    in   1      operand pair valid
//   in_ready    out  1      operand pair accepted when in_valid&in_ready
//   in_a        in   NBITS  operand 1 (posit)
//   in_b        in   NBITS  operand 2 (posit)
//   mul_in1     out  NBITS  to multiplier in1
//   mul_in2     out  NBITS  to multiplier in2
//   mul_start   out  1      to multiplier start
//   mul_result  in   NBITS  from multiplier result
//   mul_inf     in   1      from multiplier inf
//   mul_zero    in   1      from multiplier zero
//   mul_done    in   1      from multiplier done
//   out_valid   out  1      FIFO head valid
//   out_ready   in   1      consumer pops head when out_valid&out_ready
//   out_result  out  NBITS  head result
//   out_inf     out  1      head inf flag
//   out_zero    out  1      head zero flag
//   proto_err   out  1      sticky: unexpected mul_done seen
// BEHAVIOUR
//   State machine: FLUSH -> RUN. reset forces FLUSH with flush counter = LATENCY.
//   FLUSH: in_ready=0, mul_start=0, mul_done ignored (multiplier pipe not reset, may hold stale starts).
//     Counter decrements each cycle; at 1 -> RUN next cycle. Exactly LATENCY cycles in FLUSH.
//   RUN: in_ready = (fifo_count + inflight) < DEPTH, from registered counters only.
//     Must not depend combinationally on in_valid or out_ready.
//   Issue (fire = in_valid & in_ready): mul_start=1 same cycle, mul_in1=in_a, mul_in2=in_b.
//     When not firing: mul_in1=mul_in2=0, mul_start=0. Never drive X.
//   inflight counter, width $clog2(DEPTH+1): +1 on fire, -1 on accepted mul_done, both -> unchanged.
//   mul_done in RUN with inflight!=0: {mul_result,mul_inf,mul_zero} written to FIFO at that edge.
//   mul_done in RUN with inflight==0, or with FIFO full: write dropped, proto_err set (cleared only by reset).
//   FIFO: DEPTH entries of NBITS+2, first-word-fall-through, circular rd/wr pointers, wrap at DEPTH-1 -> 0.
//     out_valid = fifo_count!=0. Push and pop in the same cycle: count unchanged, both pointers advance.
//     Push and pop in the same cycle are legal with FIFO full (pop frees the slot) and with it empty.
//   Latency: accepted at cycle T -> mul_done at T+LATENCY -> out_valid earliest T+LATENCY+1.
//   Ordering: results leave in issue order. Flags pass through unmodified.
//   Reset values: in_ready=0, mul_start=0, mul_in1/2=0, out_valid=0, out_result=0, out_inf=0,
//     out_zero=0, proto_err=0. Counters and pointers 0.
//   Reset mid-operation: in-flight ops and FIFO contents discarded. No output until new ops are issued after FLUSH.
// TESTING
//   Single op 0x40000000*0x40000000 (1.0*1.0) -> out_valid exactly 5 cycles after accept; out_result=0x40000000, flags 0.
//   Single op 0x48000000*0x48000000 (2*2) -> out_result=0x50000000.
//   0x00000000*0x48000000 -> out_zero=1, out_result=0. 0x80000000*0x40000000 -> out_inf=1, out_result=0x80000000.
//   Streaming: 100 back-to-back ops, out_ready=1, DEPTH=8 -> in_ready stays 1 after FLUSH; 100 results in issue order.
//   Backpressure: out_ready=0, continuous in_valid -> exactly 8 accepts, then in_ready=0.
//     No drops, proto_err=0. Release out_ready -> all 8 drain in order.
//   Reset with 3 ops in flight -> in_ready=0 for 4 cycles; stale mul_done pulses ignored.
//     out_valid stays 0, proto_err=0. Next op completes normally.
//   Inject mul_done with inflight=0 in RUN -> proto_err=1 and stays 1; FIFO count unchanged.

Source files
------------

// File: rtl/posit_mult_stream.sv
// posit_mult_stream
//   Valid/ready streaming shell around the free-running 4-stage es=2 posit
//   multiplier. Operand pairs accepted on the input handshake are issued to the
//   multiplier as single-cycle start pulses; every completion pulse is captured
//   into a first-word-fall-through output FIFO. Issue is credit-limited so that
//   results already in the multiplier always have a FIFO slot waiting for them.
//
//   Ports
//     clk, reset              clock; synchronous active-high reset
//     in_valid/in_ready       operand handshake, in_a/in_b operands
//     mul_in1/mul_in2         operands to the multiplier (zero when not issuing)
//     mul_start               single-cycle issue pulse to the multiplier
//     mul_result/inf/zero     multiplier result and flags
//     mul_done                multiplier completion pulse
//     out_valid/out_ready     result handshake, out_result/out_inf/out_zero payload
//     proto_err               sticky: completion seen with no outstanding op or no room
module posit_mult_stream #(
   parameter int NBITS   = 32,
   parameter int LATENCY = 4,
   parameter int DEPTH   = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [NBITS-1:0] in_a,
   input  logic [NBITS-1:0] in_b,
   output logic [NBITS-1:0] mul_in1,
   output logic [NBITS-1:0] mul_in2,
   output logic             mul_start,
   input  logic [NBITS-1:0] mul_result,
   input  logic             mul_inf,
   input  logic             mul_zero,
   input  logic             mul_done,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [NBITS-1:0] out_result,
   output logic             out_inf,
   output logic             out_zero,
   output logic             proto_err
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);
   localparam int FW = $clog2(LATENCY + 1);
   localparam int EW = NBITS + 2;

   typedef enum logic {ST_FLUSH, ST_RUN} state_t;

   state_t          state_q, state_d;
   logic [FW-1:0]   flush_cnt_q;
   logic [CW-1:0]   inflight_q;
   logic [CW-1:0]   fifo_count_q;
   logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
   logic            proto_err_q;
   logic [EW-1:0]   mem [DEPTH];

   logic [CW:0]     occupancy;
   logic            fire, pop, push, room, done_run, done_take, err;
   logic [EW-1:0]   head;

   // Next state: FLUSH lasts exactly LATENCY cycles so that any starts issued
   // before reset have drained out of the multiplier before issuing resumes.
   always_comb begin
      state_d = state_q;
      if (state_q == ST_FLUSH && flush_cnt_q == FW'(1))
         state_d = ST_RUN;
   end

   // Issue and FIFO control. in_ready uses registered counters only, so it
   // never depends on in_valid or out_ready in the same cycle.
   always_comb begin
      occupancy = {1'b0, fifo_count_q} + {1'b0, inflight_q};
      in_ready  = (state_q == ST_RUN) && (occupancy < (CW+1)'(DEPTH));
      fire      = in_valid & in_ready;
      mul_start = fire;
      mul_in1   = fire ? in_a : '0;
      mul_in2   = fire ? in_b : '0;

      out_valid = (fifo_count_q != '0);
      pop       = out_valid & out_ready;
      // A pop in the same cycle frees the slot even when full.
      room      = (fifo_count_q != CW'(DEPTH)) | pop;
      done_run  = (state_q == ST_RUN) & mul_done;
      done_take = done_run & (inflight_q != '0);
      push      = done_take & room;
      err       = done_run & ~push;

      head       = mem[rd_ptr_q];
      out_result = out_valid ? head[EW-1:2] : '0;
      out_inf    = out_valid & head[1];
      out_zero   = out_valid & head[0];
      proto_err  = proto_err_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_FLUSH;
         flush_cnt_q  <= FW'(LATENCY);
         inflight_q   <= '0;
         fifo_count_q <= '0;
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         proto_err_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_FLUSH)
            flush_cnt_q <= flush_cnt_q - FW'(1);

         case ({fire, done_take})
            2'b10:   inflight_q <= inflight_q + CW'(1);
            2'b01:   inflight_q <= inflight_q - CW'(1);
            default: inflight_q <= inflight_q;
         endcase

         case ({push, pop})
            2'b10:   fifo_count_q <= fifo_count_q + CW'(1);
            2'b01:   fifo_count_q <= fifo_count_q - CW'(1);
            default: fifo_count_q <= fifo_count_q;
         endcase

         if (push)
            wr_ptr_q <= (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
         if (pop)
            rd_ptr_q <= (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);

         if (err)
            proto_err_q <= 1'b1;
      end
   end

   // Storage needs no reset: pointers and count define which entries are live.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr_q] <= {mul_result, mul_inf, mul_zero};
   end

endmodule

// File: tb/tb_posit_mult_stream.sv
module tb_posit_mult_stream;
   localparam int NB  = 32;
   localparam int LAT = 4;
   localparam int DEP = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset, in_valid, in_ready, mul_start, mul_inf, mul_zero, mul_done;
   logic          out_valid, out_ready, out_inf, out_zero, proto_err;
   logic [NB-1:0] in_a, in_b, mul_in1, mul_in2, mul_result, out_result;

   posit_mult_stream #(.NBITS(NB), .LATENCY(LAT), .DEPTH(DEP)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .mul_in1(mul_in1), .mul_in2(mul_in2),
      .mul_start(mul_start), .mul_result(mul_result), .mul_inf(mul_inf),
      .mul_zero(mul_zero), .mul_done(mul_done), .out_valid(out_valid),
      .out_ready(out_ready), .out_result(out_result), .out_inf(out_inf),
      .out_zero(out_zero), .proto_err(proto_err)
   );

   // ---------------- posit32 es=2 arithmetic reference ----------------
   function automatic void pdecode(input logic [31:0] p, output logic s,
                                   output int sc, output logic [30:0] m);
      logic [31:0] v, x;
      logic        r0;
      int          run, k;
      s   = p[31];
      v   = s ? (~p + 32'd1) : p;
      x   = v << 1;
      r0  = x[31];
      run = 0;
      while (run < 31 && x[31-run] == r0) run++;
      k  = r0 ? run - 1 : -run;
      x  = (run + 1 >= 32) ? 32'd0 : (x << (run + 1));
      sc = 4 * k + int'(x[31:30]);
      m  = {1'b1, x[29:0]};
   endfunction

   // Returns {result, inf, zero}
   function automatic logic [33:0] posit_mul(input logic [31:0] a, input logic [31:0] b);
      logic        sa, sb, sg, rnd, sticky;
      int          sca, scb, sc, k, e, pos;
      logic [30:0] ma, mb, body;
      logic [61:0] pr;
      logic [60:0] f;
      logic [127:0] bits;
      logic [31:0] res;
      if (a == 32'h80000000 || b == 32'h80000000) return {32'h80000000, 2'b10};
      if (a == 32'h0 || b == 32'h0) return {32'h0, 2'b01};
      pdecode(a, sa, sca, ma);
      pdecode(b, sb, scb, mb);
      sg = sa ^ sb;
      pr = 62'(ma) * 62'(mb);
      sc = sca + scb;
      if (pr[61]) begin sc = sc + 1; f = pr[60:0]; end
      else f = {pr[59:0], 1'b0};
      if (sc > 120) body = 31'h7FFFFFFF;
      else if (sc < -120) body = 31'h1;
      else begin
         k = sc >>> 2;
         e = sc - 4 * k;
         bits = '0;
         pos = 127;
         if (k >= 0) begin
            for (int i = 0; i < k + 1; i++) begin bits[pos] = 1'b1; pos--; end
            pos--;
         end else begin
            pos = pos + k;
            bits[pos] = 1'b1; pos--;
         end
         bits[pos] = e[1]; bits[pos-1] = e[0]; pos = pos - 2;
         for (int i = 0; i < 61; i++) bits[pos-i] = f[60-i];
         body   = bits[127:97];
         rnd    = bits[96];
         sticky = |bits[95:0];
         if (rnd && (sticky || body[0])) body = body + 31'd1;
      end
      res = sg ? (~{1'b0, body} + 32'd1) : {1'b0, body};
      return {res, 2'b00};
   endfunction

   // ---------------- multiplier stand-in: 4-cycle pipe, not reset ----------------
   logic [3:0]  pv = '0;
   logic [33:0] pr [4];
   logic        inj_done = 1'b0;
   logic [31:0] inj_res  = '0;
   always @(posedge clk) begin
      pv    <= {pv[2:0], mul_start};
      pr[0] <= posit_mul(mul_in1, mul_in2);
      pr[1] <= pr[0];
      pr[2] <= pr[1];
      pr[3] <= pr[2];
   end
   assign mul_done   = pv[3] | inj_done;
   assign mul_result = inj_done ? inj_res : pr[3][33:2];
   assign mul_inf    = inj_done ? 1'b0 : pr[3][1];
   assign mul_zero   = inj_done ? 1'b0 : pr[3][0];

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_fail   = 0;
   int n_pops   = 0;
   bit mon_en   = 0;
   logic [33:0] exp_q [$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard: results must leave in issue order; issue port must be clean.
   always @(negedge clk) begin
      if (mon_en) begin
         if (reset) exp_q.delete();
         else begin
            if (in_valid && in_ready) begin
               check("issue_port", {mul_start, mul_in1, mul_in2}, {1'b1, in_a, in_b});
               exp_q.push_back(posit_mul(in_a, in_b));
            end else
               check("idle_port", {mul_start, mul_in1, mul_in2}, 64'd0);
            if (out_valid && out_ready) begin
               n_pops++;
               if (exp_q.size() == 0) begin
                  n_checks++; n_fail++;
                  $display("FAIL unexpected_out: got %0h with nothing outstanding", out_result);
               end else
                  check("sb_order", {out_result, out_inf, out_zero}, exp_q.pop_front());
            end
         end
      end
   end

   function automatic logic [31:0] rand_op();
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) return 32'h0;
      if (r == 1) return 32'h80000000;
      return $urandom;
   endfunction

   task automatic wait_flush(output int n, output int ov);
      n = 0; ov = 0;
      do begin
         @(negedge clk);
         if (out_valid) ov++;
         if (!in_ready) n++;
      end while (!in_ready && n < 20);
   endtask

   task automatic do_reset();
      int n, ov;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      wait_flush(n, ov);
      check("flush_cycles", n, 4);
      check("flush_no_output", ov, 0);
   endtask

   task automatic send_one(input logic [31:0] a, input logic [31:0] b, output int lat);
      int w;
      @(posedge clk); #1;
      in_a = a; in_b = b; in_valid = 1'b1;
      w = 0;
      @(negedge clk);
      while (!in_ready && w < 50) begin @(negedge clk); w++; end
      if (w >= 50) check("accept_timeout", w, 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      do begin @(negedge clk); lat++; end while (!out_valid && lat < 30);
   endtask

   typedef struct {
      logic [31:0] a, b, r;
      logic        inf, zero;
   } vec_t;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs [10];
      int lat, sent, stalls, accepts, cyc, pops0, n, ov;
      logic [31:0] a, b;

      vecs[0] = '{32'h40000000, 32'h40000000, 32'h40000000, 1'b0, 1'b0};
      vecs[1] = '{32'h48000000, 32'h48000000, 32'h50000000, 1'b0, 1'b0};
      vecs[2] = '{32'h00000000, 32'h48000000, 32'h00000000, 1'b0, 1'b1};
      vecs[3] = '{32'h80000000, 32'h40000000, 32'h80000000, 1'b1, 1'b0};
      vecs[4] = '{32'h44000000, 32'h44000000, 32'h49000000, 1'b0, 1'b0};
      vecs[5] = '{32'hC0000000, 32'h48000000, 32'hB8000000, 1'b0, 1'b0};
      vecs[6] = '{32'h38000000, 32'h48000000, 32'h40000000, 1'b0, 1'b0};
      vecs[7] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 1'b0};
      vecs[8] = '{32'h00000001, 32'h00000001, 32'h00000001, 1'b0, 1'b0};
      vecs[9] = '{32'h00000000, 32'h80000000, 32'h80000000, 1'b1, 1'b0};

      reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_mul_start", mul_start, 0);
      check("rst_mul_in", {mul_in1, mul_in2}, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_payload", {out_result, out_inf, out_zero}, 0);
      check("rst_proto_err", proto_err, 0);
      mon_en = 1;
      do_reset();

      // Directed vectors, one at a time
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         send_one(vecs[i].a, vecs[i].b, lat);
         check("vec_latency", lat, 5);
         check("vec_result", {out_result, out_inf, out_zero},
               {vecs[i].r, vecs[i].inf, vecs[i].zero});
      end
      @(posedge clk); #1;

      // Back-to-back random streaming
      sent = 0; stalls = 0; cyc = 0; pops0 = n_pops;
      in_a = rand_op(); in_b = rand_op(); in_valid = 1'b1;
      while (sent < 100 && cyc < 1000) begin
         @(negedge clk);
         cyc++;
         if (in_ready) sent++; else stalls++;
         @(posedge clk); #1;
         if (in_ready || 1'b1) begin in_a = rand_op(); in_b = rand_op(); end
      end
      in_valid = 1'b0;
      cyc = 0;
      while (exp_q.size() != 0 && cyc < 200) begin @(negedge clk); cyc++; end
      check("stream_stalls", stalls, 0);
      check("stream_count", n_pops - pops0, 100);
      check("stream_sb_empty", exp_q.size(), 0);

      // Backpressure: FIFO plus in-flight credits cap accepts at DEPTH
      out_ready = 1'b0; accepts = 0;
      @(posedge clk); #1;
      in_a = rand_op(); in_b = rand_op(); in_valid = 1'b1;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (in_ready) accepts++;
         @(posedge clk); #1;
         in_a = rand_op(); in_b = rand_op();
      end
      @(negedge clk);
      check("bp_accepts", accepts, DEP);
      check("bp_in_ready", in_ready, 0);
      check("bp_proto_err", proto_err, 0);
      check("bp_out_valid", out_valid, 1);
      @(posedge clk); #1;
      in_valid = 1'b0; pops0 = n_pops; out_ready = 1'b1;
      cyc = 0;
      while (exp_q.size() != 0 && cyc < 100) begin @(negedge clk); cyc++; end
      @(negedge clk);
      check("bp_drained", n_pops - pops0, DEP);
      check("bp_empty", out_valid, 0);

      // Reset with three ops in flight
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         in_a = rand_op(); in_b = rand_op(); in_valid = 1'b1;
         @(negedge clk);
         check("mid_accept", in_ready, 1);
      end
      @(posedge clk); #1;
      in_valid = 1'b0; reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      wait_flush(n, ov);
      check("mid_flush_cycles", n, 4);
      check("mid_no_output", ov, 0);
      ov = 0;
      repeat (6) begin @(negedge clk); if (out_valid) ov++; end
      check("mid_quiet", ov, 0);
      check("mid_proto_err", proto_err, 0);
      send_one(32'h48000000, 32'h44000000, lat);
      check("post_rst_latency", lat, 5);
      check("post_rst_result", {out_result, out_inf, out_zero}, {32'h4C000000, 2'b00});

      // Unexpected completion while idle
      @(posedge clk); #1;
      @(posedge clk); #1;
      inj_res = $urandom; inj_done = 1'b1;
      @(posedge clk); #1;
      inj_done = 1'b0;
      @(negedge clk);
      check("inj_proto_err", proto_err, 1);
      check("inj_no_push", out_valid, 0);
      repeat (5) @(negedge clk);
      check("inj_sticky", proto_err, 1);
      check("inj_ready", in_ready, 1);
      a = 32'h40000000; b = 32'h48000000;
      send_one(a, b, lat);
      check("inj_next_latency", lat, 5);
      check("inj_next_result", {out_result, out_inf, out_zero}, {32'h48000000, 2'b00});
      @(posedge clk); #1;
      do_reset();
      check("inj_cleared", proto_err, 0);

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
